// File: rtl/pll_clkdiv_ctrl.sv
// pll_clkdiv_ctrl: lock-qualified multi-channel clock-enable generator.
// Filters PLL lock, then runs NUM_CH phase-aligned divided channels and supervises lock loss.
module pll_clkdiv_ctrl #(
   parameter int NUM_CH    = 4,
   parameter int DIV_W     = 8,
   parameter int LOCK_FILT = 16,
   parameter int DEF_DIV   = 1
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    pll_locked,
   input  logic                    cfg_load,
   input  logic [NUM_CH*DIV_W-1:0] cfg_div,
   input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
   input  logic [NUM_CH-1:0]       cfg_ch_en,
   input  logic                    lock_lost_clr,
   output logic [NUM_CH-1:0]       outclk,
   output logic [NUM_CH-1:0]       ce,
   output logic                    locked,
   output logic                    lock_lost,
   output logic [7:0]              relock_cnt
);
   localparam int FW = $clog2(LOCK_FILT);
   typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RUN} state_t;
   state_t            st, st_n;
   logic              lk_m, lk_s, loss, restart;
   logic [FW-1:0]     filt;
   logic [DIV_W-1:0]  div_q [NUM_CH];
   logic [DIV_W-1:0]  ph_q  [NUM_CH];
   logic [DIV_W-1:0]  cnt_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_n [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_n, ce_n, oc_n;
   assign st_n = !lk_s ? WAIT_LOCK :
                 st == WAIT_LOCK ? QUALIFY :
                 (st == QUALIFY && filt == FW'(LOCK_FILT-1)) ? RUN : st;
   assign loss    = st == RUN && !lk_s;
   assign restart = st_n == RUN && (st != RUN || cfg_load);
   // Outputs decode the next-cycle count so they can be registered glitch-free.
   always_comb begin
      en_n = cfg_load ? cfg_ch_en : en_q;
      for (int i = 0; i < NUM_CH; i++) begin
         logic [DIV_W-1:0] ld_d, ld_p;
         logic [DIV_W:0]   half;
         ld_d = cfg_load ? cfg_div[i*DIV_W +: DIV_W] : div_q[i];
         ld_p = cfg_load ? cfg_phase[i*DIV_W +: DIV_W] : ph_q[i];
         half = ({1'b0, ld_d} + (DIV_W+1)'(2)) >> 1;
         cnt_n[i] = st_n != RUN ? '0 :
                    restart ? (ld_p > ld_d ? ld_d : ld_p) :
                    cnt_q[i] == div_q[i] ? '0 : cnt_q[i] + 1'b1;
         ce_n[i] = st_n == RUN && en_n[i] && cnt_n[i] == '0;
         oc_n[i] = st_n == RUN && en_n[i] && {1'b0, cnt_n[i]} < half;
      end
   end
   always_ff @(posedge refclk or posedge rst)
      if (rst) begin
         lk_m       <= 1'b0;
         lk_s       <= 1'b0;
         st         <= WAIT_LOCK;
         filt       <= '0;
         en_q       <= '1;
         outclk     <= '0;
         ce         <= '0;
         locked     <= 1'b0;
         lock_lost  <= 1'b0;
         relock_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= DIV_W'(DEF_DIV);
            ph_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         lk_m       <= pll_locked;
         lk_s       <= lk_m;
         st         <= st_n;
         filt       <= st == QUALIFY ? filt + 1'b1 : '0;
         en_q       <= en_n;
         outclk     <= oc_n;
         ce         <= ce_n;
         locked     <= st_n == RUN;
         lock_lost  <= loss || (lock_lost && !lock_lost_clr);
         relock_cnt <= relock_cnt + 8'(loss && relock_cnt != 8'hFF);
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_n[i];
            if (cfg_load) begin
               div_q[i] <= cfg_div[i*DIV_W +: DIV_W];
               ph_q[i]  <= cfg_phase[i*DIV_W +: DIV_W];
            end
         end
      end
endmodule

// File: tb/tb_pll_clkdiv_ctrl.sv
// tb_pll_clkdiv_ctrl: directed self-checking bench for pll_clkdiv_ctrl.
module tb_pll_clkdiv_ctrl;
   logic        refclk, rst, pll_locked, cfg_load, lock_lost_clr;
   logic [31:0] cfg_div, cfg_phase;
   logic [3:0]  cfg_ch_en, outclk, ce;
   logic        locked, lock_lost;
   logic [7:0]  relock_cnt;
   logic [7:0]  ce_v [4];
   logic [7:0]  oc_v [4];
   int          n_cmp, n_err, n, tmo;

   pll_clkdiv_ctrl #(.NUM_CH(4), .DIV_W(8), .LOCK_FILT(16), .DEF_DIV(1)) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_load(cfg_load),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_ch_en(cfg_ch_en),
      .lock_lost_clr(lock_lost_clr), .outclk(outclk), .ce(ce), .locked(locked),
      .lock_lost(lock_lost), .relock_cnt(relock_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge refclk);
   endtask

   task automatic wait_locked(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge refclk);
         if (locked) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic rec(input int len);
      for (int c = 0; c < 4; c++) begin
         ce_v[c] = '0;
         oc_v[c] = '0;
      end
      for (int k = 0; k < len; k++) begin
         for (int c = 0; c < 4; c++) begin
            ce_v[c][k] = ce[c];
            oc_v[c][k] = outclk[c];
         end
         tick(1);
      end
   endtask

   task automatic load(input logic [31:0] d, input logic [31:0] p, input logic [3:0] en);
      cfg_div   = d;
      cfg_phase = p;
      cfg_ch_en = en;
      cfg_load  = 1'b1;
      tick(1);
      cfg_load  = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; tmo = 0;
      rst = 1'b1; pll_locked = 1'b0; cfg_load = 1'b0; lock_lost_clr = 1'b0;
      cfg_div = '0; cfg_phase = '0; cfg_ch_en = '0;
      tick(2);
      check("rst_outclk", outclk, 0);
      check("rst_ce", ce, 0);
      check("rst_locked", locked, 0);
      check("rst_lost", lock_lost, 0);
      check("rst_relock", relock_cnt, 0);
      // lock glitch during qualification restarts the filter
      pll_locked = 1'b1;
      rst = 1'b0;
      tick(8);
      pll_locked = 1'b0;
      tick(3);
      check("glitch_locked", locked, 0);
      pll_locked = 1'b1;
      wait_locked(n);
      check("lock_latency", n >= 18 && n <= 20, 1);
      check("glitch_lost", lock_lost, 0);
      check("glitch_relock", relock_cnt, 0);
      rec(4);
      check("def_ce0", ce_v[0][3:0], 4'h5);
      check("def_oc0", oc_v[0][3:0], 4'h5);
      check("def_ce3", ce_v[3][3:0], 4'h5);
      // ch0 D3/ph0, ch1 D3/ph2, ch2 D4, ch3 D1
      load({8'd1, 8'd4, 8'd3, 8'd3}, {8'd0, 8'd0, 8'd2, 8'd0}, 4'hF);
      rec(8);
      check("d3_ce0", ce_v[0], 8'h11);
      check("d3_oc0", oc_v[0], 8'h33);
      check("d3p2_ce1", ce_v[1], 8'h44);
      check("d3p2_oc1", oc_v[1], 8'hCC);
      check("d4_ce2", ce_v[2], 8'h21);
      check("d4_oc2", oc_v[2], 8'hE7);
      // phase clamp and D=0
      load({8'd1, 8'd0, 8'd3, 8'd3}, {8'd0, 8'd0, 8'd9, 8'd0}, 4'hF);
      rec(8);
      check("clamp_ce1", ce_v[1], 8'h22);
      check("clamp_oc1", oc_v[1], 8'h66);
      check("d0_ce2", ce_v[2], 8'hFF);
      check("d0_oc2", oc_v[2], 8'hFF);
      // channel disable then re-enable
      load({8'd1, 8'd3, 8'd3, 8'd3}, 32'd0, 4'b1011);
      rec(8);
      check("dis_ce2", ce_v[2], 8'h00);
      check("dis_oc2", oc_v[2], 8'h00);
      check("dis_ce0", ce_v[0], 8'h11);
      load({8'd1, 8'd3, 8'd3, 8'd3}, 32'd0, 4'hF);
      rec(8);
      check("reen_ce2", ce_v[2], 8'h11);
      check("reen_oc2", oc_v[2], 8'h33);
      // lock loss in RUN
      pll_locked = 1'b0;
      tick(3);
      check("loss_outclk", outclk, 0);
      check("loss_ce", ce, 0);
      check("loss_locked", locked, 0);
      check("loss_lost", lock_lost, 1);
      check("loss_relock", relock_cnt, 1);
      lock_lost_clr = 1'b1;
      tick(1);
      lock_lost_clr = 1'b0;
      check("clr_lost", lock_lost, 0);
      for (int r = 0; r < 299; r++) begin
         pll_locked = 1'b1;
         wait_locked(n);
         if (n < 0) tmo++;
         pll_locked = 1'b0;
         tick(4);
      end
      check("relock_timeouts", tmo, 0);
      check("relock_sat", relock_cnt, 8'hFF);
      // clear and loss in the same cycle: set wins
      pll_locked = 1'b1;
      wait_locked(n);
      check("relock_latency", n >= 18 && n <= 20, 1);
      lock_lost_clr = 1'b1;
      tick(1);
      lock_lost_clr = 1'b0;
      check("clr_lost2", lock_lost, 0);
      pll_locked = 1'b0;
      tick(2);
      lock_lost_clr = 1'b1;
      tick(1);
      lock_lost_clr = 1'b0;
      check("clr_vs_set", lock_lost, 1);
      check("clr_vs_set_locked", locked, 0);
      // asynchronous reset mid-RUN, config returns to default
      pll_locked = 1'b1;
      wait_locked(n);
      check("pre_rst_locked", locked, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_outclk", outclk, 0);
      check("arst_ce", ce, 0);
      check("arst_locked", locked, 0);
      check("arst_relock", relock_cnt, 0);
      tick(1);
      rst = 1'b0;
      wait_locked(n);
      check("post_rst_latency", n >= 18 && n <= 20, 1);
      rec(4);
      check("post_rst_ce0", ce_v[0][3:0], 4'h5);
      check("post_rst_oc1", oc_v[1][3:0], 4'h5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pll_clkdiv_ctrl.md
Name: pll_clkdiv_ctrl

Overview:
Lock-qualified, multi-channel clock-enable generator driven by the PLL output clock. It filters the raw PLL lock signal and derives NUM_CH phase-aligned divided channels from the single fast clock. Each channel has a runtime divide ratio and phase offset, and produces a divided square wave and a one-cycle clock-enable pulse. It also records loss-of-lock events for system supervision.

Parameters:
NUM_CH, 4, number of output channels (1..16)
DIV_W, 8, width of per-channel divide and phase fields
LOCK_FILT, 16, cycles pll_locked must stay high before outputs start (>=2)
DEF_DIV, 1, reset value of every channel's divide field (period = DEF_DIV+1)

Ports:
refclk  in  1  block clock (PLL output domain)
rst  in  1  asynchronous reset, active-high
pll_locked  in  1  raw PLL lock, asynchronous; 2-flop synchronised internally
cfg_load  in  1  one-cycle strobe; latches cfg_div/cfg_phase/cfg_ch_en
cfg_div  in  NUM_CH*DIV_W  per-channel divide field D, channel i at [i*DIV_W +: DIV_W]; period P = D+1 cycles
cfg_phase  in  NUM_CH*DIV_W  per-channel start count, same packing
cfg_ch_en  in  NUM_CH  per-channel enable
lock_lost_clr  in  1  clears lock_lost
outclk  out  NUM_CH  divided square waves
ce  out  NUM_CH  one-cycle enable pulse per period
locked  out  1  qualified lock (high only in RUN)
lock_lost  out  1  sticky: set when lock dropped while in RUN
relock_cnt  out  8  saturating count of lock-loss events

Behaviour:
- Reset (async, rst=1): state=WAIT_LOCK, filter counter=0, all channel counters=0, and all outputs 0 (outclk, ce, locked, lock_lost, relock_cnt).
- Reset loads the shadow config as follows: D=DEF_DIV, phase=0, ch_en all ones.
- lk_s is pll_locked after the 2-flop synchroniser (2-cycle latency).
- FSM states:
  - WAIT_LOCK: when lk_s=1, go to QUALIFY and set filter counter to 0.
  - QUALIFY: filter counter increments each cycle. If lk_s=0, return to WAIT_LOCK with no flag set. When the counter reaches LOCK_FILT-1 with lk_s=1, go to RUN.
  - RUN: locked=1. If lk_s=0, go to WAIT_LOCK next cycle. On that transition, set lock_lost and increment relock_cnt, saturating at 255. Channel counters are cleared; outclk, ce and locked read 0 from that cycle on.
- Channel counter cnt_i:
  - On the first RUN cycle, cnt_i = min(phase_i, D_i).
  - Each later cycle, cnt_i = (cnt_i == D_i) ? 0 : cnt_i+1.
- Channel outputs are registered. The value in a cycle decodes that cycle's cnt_i (compute from next-state), so there are no combinational output glitches.
  - ce[i] = RUN & en_i & (cnt_i == 0).
  - outclk[i] = RUN & en_i & (cnt_i < ceil(P_i/2)). Odd P gives the extra cycle high.
- D=0 (P=1): ce[i] is high every RUN cycle and outclk[i] is held high.
- Disabled channel: its counter keeps running so it stays aligned; only the outputs are forced 0. Re-enabling resumes in phase.
- cfg_load handling:
  - cfg_load latches the shadow config in any state. In WAIT_LOCK/QUALIFY it takes effect at RUN entry.
  - cfg_load in RUN: on the next cycle all counters reload min(phase_i, D_i) simultaneously (synchronous restart). Outputs then follow the new decode from that cycle on, and cycles may be truncated.
- lock_lost_clr clears lock_lost. If a loss event happens in the same cycle, set wins. relock_cnt is cleared only by rst.
- Lock loss coinciding with cfg_load: the config is still latched, and the FSM goes to WAIT_LOCK.
- All arithmetic is unsigned, DIV_W wide. A phase greater than D is clamped to D.

Test Plan:
1. Reset release with pll_locked=1 and LOCK_FILT=16 -> locked rises 2+16 cycles (±1) after lk path settles; ch0 D=1: ce pattern 1,0,1,0 and outclk 1,0.
2. Glitch pll_locked low for 3 cycles during QUALIFY -> locked stays 0, filter restarts, lock_lost=0, relock_cnt=0.
3. In RUN, drop pll_locked -> all outclk/ce/locked=0 within 3 cycles, lock_lost=1, relock_cnt=1. Repeat 300 times -> relock_cnt saturates at 255.
4. cfg_load with ch0 D=3/phase 0 and ch1 D=3/phase 2 -> ch0 ce on counts 0,4,8; ch1 ce 2 cycles earlier; outclk duty 2/4. Then ch2 D=4 -> high 3, low 2.
5. ch1 phase=9 with D=3 -> behaves as phase 3. ch2 D=0 -> ce continuously high. cfg_ch_en[2]=0 then 1 -> outputs resume aligned with the uninterrupted count.
6. Assert rst mid-RUN -> all outputs 0 immediately (asynchronous), shadow config returns to DEF_DIV. Same-cycle lock_lost_clr and lock loss -> lock_lost=1.
